// File: rtl/video_pattern_gen.sv
// Test-pattern overlay between the timing generator and the DVI TX encoder.
// Optional build macro PATTERN_SCROLL_EN adds a frame counter that scrolls the ramp and checker patterns.
module video_pattern_gen #(
  parameter int BAR_NUM    = 8,
  parameter int GRID_SHIFT = 5
) (
  input  logic        pxl_clk,
  input  logic        rst_b,
  input  logic        i_de,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic [2:0]  i_mode,
  input  logic [15:0] i_hres,
  input  logic [23:0] i_solid_rgb,
  output logic        o_de,
  output logic        o_hs,
  output logic        o_vs,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b
);

  localparam logic [2:0] MODE_BARS    = 3'd0;
  localparam logic [2:0] MODE_GRID    = 3'd1;
  localparam logic [2:0] MODE_RAMP    = 3'd2;
  localparam logic [2:0] MODE_CHECKER = 3'd3;
  localparam logic [2:0] MODE_SOLID   = 3'd4;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  logic        r_de;
  logic        r_hs;
  logic        r_vs;
  logic [23:0] r_rgb;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [2:0]  r_mode;
  logic [15:0] r_bar_cnt;
  logic [2:0]  r_bar_idx;

  logic        w_vs_fall;
  logic        w_de_fall;
  logic [15:0] w_bar_w_raw;
  logic [15:0] w_bar_w;
  logic        w_bar_last;
  logic [7:0]  w_ramp;
  logic        w_chk_x;
  logic [23:0] w_rgb;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    if (int'(idx) >= BAR_NUM) begin
      c = BLACK;
    end else begin
      case (idx)
        3'd0:    c = 24'hFFFFFF;
        3'd1:    c = 24'hFFFF00;
        3'd2:    c = 24'h00FFFF;
        3'd3:    c = 24'h00FF00;
        3'd4:    c = 24'hFF00FF;
        3'd5:    c = 24'hFF0000;
        3'd6:    c = 24'h0000FF;
        default: c = 24'h000000;
      endcase
    end
    return c;
  endfunction

  // r_de/r_vs double as the previous-cycle values for edge detection
  assign w_vs_fall   = r_vs & ~i_vs;
  assign w_de_fall   = r_de & ~i_de;
  assign w_bar_w_raw = i_hres >> 3;
  assign w_bar_w     = (w_bar_w_raw == 16'd0) ? 16'd1 : w_bar_w_raw;
  assign w_bar_last  = (r_bar_cnt == w_bar_w - 16'd1);

`ifdef PATTERN_SCROLL_EN
  logic [7:0]          r_frame_cnt;
  logic [GRID_SHIFT:0] w_x_chk_sum;

  always_ff @(posedge pxl_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_frame_cnt <= 8'd0;
    end else if (w_vs_fall) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Only the low GRID_SHIFT+1 bits of the sum decide the checker column
  assign w_x_chk_sum = r_x[GRID_SHIFT:0] + (GRID_SHIFT+1)'(r_frame_cnt);
  assign w_ramp      = r_x[7:0] + r_frame_cnt;
  assign w_chk_x     = w_x_chk_sum[GRID_SHIFT];
`else
  assign w_ramp      = r_x[7:0];
  assign w_chk_x     = r_x[GRID_SHIFT];
`endif

  always_comb begin
    w_rgb = BLACK;
    if (i_de) begin
      case (r_mode)
        MODE_BARS:    w_rgb = bar_colour(r_bar_idx);
        MODE_GRID:    w_rgb = ((r_x[GRID_SHIFT-1:0] == '0) || (r_y[GRID_SHIFT-1:0] == '0))
                              ? WHITE : BLACK;
        MODE_RAMP:    w_rgb = {w_ramp, w_ramp, w_ramp};
        MODE_CHECKER: w_rgb = (w_chk_x ^ r_y[GRID_SHIFT]) ? WHITE : BLACK;
        MODE_SOLID:   w_rgb = i_solid_rgb;
        default:      w_rgb = BLACK;
      endcase
    end
  end

  always_ff @(posedge pxl_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_de      <= 1'b0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_rgb     <= 24'h0;
      r_x       <= 16'd0;
      r_y       <= 16'd0;
      r_mode    <= 3'd0;
      r_bar_cnt <= 16'd0;
      r_bar_idx <= 3'd0;
    end else begin
      r_de  <= i_de;
      r_hs  <= i_hs;
      r_vs  <= i_vs;
      r_rgb <= w_rgb;

      r_x <= i_de ? r_x + 16'd1 : 16'd0;

      // Frame start clear takes priority over a coincident line-end increment
      if (w_vs_fall) begin
        r_y <= 16'd0;
      end else if (w_de_fall) begin
        r_y <= r_y + 16'd1;
      end

      if (w_vs_fall) begin
        r_mode <= i_mode;
      end

      if (!i_de) begin
        r_bar_cnt <= 16'd0;
        r_bar_idx <= 3'd0;
      end else if (w_bar_last) begin
        r_bar_cnt <= 16'd0;
        r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + 16'd1;
      end
    end
  end

  assign o_de = r_de;
  assign o_hs = r_hs;
  assign o_vs = r_vs;
  assign o_r  = r_rgb[23:16];
  assign o_g  = r_rgb[15:8];
  assign o_b  = r_rgb[7:0];

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: reset, each pattern, mode latching and bar edge cases.
module tb_video_pattern_gen;

`ifdef PATTERN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        pxl_clk;
  logic        rst_b;
  logic        i_de, i_hs, i_vs;
  logic [2:0]  i_mode;
  logic [15:0] i_hres;
  logic [23:0] i_solid_rgb;
  logic        o_de, o_hs, o_vs;
  logic [7:0]  o_r, o_g, o_b;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_frames = 0;

  logic [23:0] pal [8];

  video_pattern_gen #(.BAR_NUM(8), .GRID_SHIFT(5)) dut (
    .pxl_clk    (pxl_clk),
    .rst_b      (rst_b),
    .i_de       (i_de),
    .i_hs       (i_hs),
    .i_vs       (i_vs),
    .i_mode     (i_mode),
    .i_hres     (i_hres),
    .i_solid_rgb(i_solid_rgb),
    .o_de       (o_de),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_r        (o_r),
    .o_g        (o_g),
    .o_b        (o_b)
  );

  initial pxl_clk = 1'b0;
  always #5 pxl_clk = ~pxl_clk;

  // Apply one cycle of inputs; outputs sampled afterwards reflect exactly these inputs
  task automatic step(input logic de, input logic hs, input logic vs);
    i_de = de;
    i_hs = hs;
    i_vs = vs;
    @(posedge pxl_clk);
    #1;
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    tb_frames++;
  endtask

  function automatic logic [7:0] scroll_off();
    return SCROLL ? 8'(tb_frames) : 8'd0;
  endfunction

  task automatic test_reset();
    rst_b = 1'b0;
    i_mode = 3'd3;
    i_hres = 16'd64;
    i_solid_rgb = 24'h123456;
    for (int i = 0; i < 4; i++) begin
      step(i[0], ~i[0], i[1]);
      n_cmp++;
      if ({o_de, o_hs, o_vs, o_r, o_g, o_b} !== {1'b0, 1'b1, 1'b1, 24'h0}) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got de/hs/vs=%b%b%b rgb=%02h%02h%02h exp 011 000000",
                 i, o_de, o_hs, o_vs, o_r, o_g, o_b);
      end
    end
    step(1'b0, 1'b1, 1'b1);
    rst_b = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({o_de, o_hs, o_vs} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_release_sync got %b%b%b exp 001", o_de, o_hs, o_vs);
    end
    step(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({o_de, o_hs, o_vs} !== 3'b011) begin
      n_bad++;
      $display("FAIL reset_hs_return got %b%b%b exp 011", o_de, o_hs, o_vs);
    end
    // Mode input is 3 but latched mode stays 0 (bars) until the first VS fall
    for (int x = 0; x < 9; x++) begin
      step(1'b1, 1'b1, 1'b1);
      if (x == 0 || x == 8) begin
        n_cmp++;
        if ({o_de, o_r, o_g, o_b} !== {1'b1, pal[x / 8]}) begin
          n_bad++;
          $display("FAIL reset_mode0 x=%0d got %b/%02h%02h%02h exp 1/%06h",
                   x, o_de, o_r, o_g, o_b, pal[x / 8]);
        end
      end
    end
    step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_bars();
    i_hres = 16'd64;
    i_mode = 3'd0;
    vs_pulse();
    for (int x = 0; x < 64; x++) begin
      step(1'b1, 1'b1, 1'b1);
      n_cmp++;
      if ({o_de, o_r, o_g, o_b} !== {1'b1, pal[x / 8]}) begin
        n_bad++;
        $display("FAIL bars x=%0d got %b/%02h%02h%02h exp 1/%06h", x, o_de, o_r, o_g, o_b, pal[x / 8]);
      end
    end
    step(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({o_de, o_r, o_g, o_b} !== 25'h0) begin
      n_bad++;
      $display("FAIL bars_de_low got %b/%02h%02h%02h exp 0/000000", o_de, o_r, o_g, o_b);
    end
  endtask

  task automatic test_grid();
    logic [23:0] exp;
    i_mode = 3'd1;
    vs_pulse();
    for (int l = 0; l < 4; l++) begin
      for (int x = 0; x < 40; x++) begin
        step(1'b1, 1'b1, 1'b1);
        exp = (l == 0 || x == 0 || x == 32) ? 24'hFFFFFF : 24'h0;
        n_cmp++;
        if ({o_r, o_g, o_b} !== exp) begin
          n_bad++;
          $display("FAIL grid l=%0d x=%0d got %02h%02h%02h exp %06h", l, x, o_r, o_g, o_b, exp);
        end
      end
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_checker();
    logic [23:0] exp;
    int xe;
    i_mode = 3'd3;
    vs_pulse();
    for (int x = 0; x < 70; x++) begin
      step(1'b1, 1'b1, 1'b1);
      xe = x + int'(scroll_off());
      exp = (((xe >> 5) & 1) == 1) ? 24'hFFFFFF : 24'h0;
      n_cmp++;
      if ({o_r, o_g, o_b} !== exp) begin
        n_bad++;
        $display("FAIL checker x=%0d got %02h%02h%02h exp %06h", x, o_r, o_g, o_b, exp);
      end
    end
    step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_mode_change();
    logic [7:0] exp;
    i_hres = 16'd64;
    i_mode = 3'd0;
    vs_pulse();
    for (int l = 0; l < 12; l++) begin
      if (l == 10) i_mode = 3'd2;
      for (int x = 0; x < 64; x++) begin
        step(1'b1, 1'b1, 1'b1);
        if (l >= 10) begin
          n_cmp++;
          if ({o_r, o_g, o_b} !== pal[x / 8]) begin
            n_bad++;
            $display("FAIL midframe_bars l=%0d x=%0d got %02h%02h%02h exp %06h",
                     l, x, o_r, o_g, o_b, pal[x / 8]);
          end
        end
      end
      step(1'b0, 1'b1, 1'b1);
    end
    vs_pulse();
    for (int x = 0; x < 300; x++) begin
      step(1'b1, 1'b1, 1'b1);
      if (x == 0 || x == 1 || x == 255 || x == 256 || x == 299) begin
        exp = 8'(x) + scroll_off();
        n_cmp++;
        if ({o_r, o_g, o_b} !== {exp, exp, exp}) begin
          n_bad++;
          $display("FAIL ramp x=%0d got %02h%02h%02h exp %02h each", x, o_r, o_g, o_b, exp);
        end
      end
    end
    step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_bar_edge();
    i_hres = 16'd4;
    i_mode = 3'd0;
    vs_pulse();
    for (int x = 0; x < 12; x++) begin
      step(1'b1, 1'b1, 1'b1);
      n_cmp++;
      if ({o_r, o_g, o_b} !== pal[(x > 7) ? 7 : x]) begin
        n_bad++;
        $display("FAIL bar_edge x=%0d got %02h%02h%02h exp %06h",
                 x, o_r, o_g, o_b, pal[(x > 7) ? 7 : x]);
      end
    end
    step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_solid();
    i_mode = 3'd4;
    i_solid_rgb = 24'h123456;
    vs_pulse();
    step(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({o_r, o_g, o_b} !== 24'h123456) begin
      n_bad++;
      $display("FAIL solid_a got %02h%02h%02h exp 123456", o_r, o_g, o_b);
    end
    i_solid_rgb = 24'hABCDEF;
    step(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({o_r, o_g, o_b} !== 24'hABCDEF) begin
      n_bad++;
      $display("FAIL solid_b got %02h%02h%02h exp abcdef", o_r, o_g, o_b);
    end
    step(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({o_de, o_r, o_g, o_b} !== 25'h0) begin
      n_bad++;
      $display("FAIL solid_de_low got %b/%02h%02h%02h exp 0/000000", o_de, o_r, o_g, o_b);
    end
    i_mode = 3'd5;
    vs_pulse();
    step(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({o_de, o_r, o_g, o_b} !== {1'b1, 24'h0}) begin
      n_bad++;
      $display("FAIL mode5_black got %b/%02h%02h%02h exp 1/000000", o_de, o_r, o_g, o_b);
    end
    step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_scroll();
    logic [7:0] exp;
    i_mode = 3'd2;
    for (int f = 0; f < 260; f++) begin
      vs_pulse();
      step(1'b1, 1'b1, 1'b1);
      exp = scroll_off();
      n_cmp++;
      if ({o_r, o_g, o_b} !== {exp, exp, exp}) begin
        n_bad++;
        $display("FAIL scroll frame=%0d got %02h%02h%02h exp %02h each", tb_frames, o_r, o_g, o_b, exp);
      end
      step(1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    pal[0] = 24'hFFFFFF; pal[1] = 24'hFFFF00; pal[2] = 24'h00FFFF; pal[3] = 24'h00FF00;
    pal[4] = 24'hFF00FF; pal[5] = 24'hFF0000; pal[6] = 24'h0000FF; pal[7] = 24'h000000;
    rst_b = 1'b0;
    i_de = 1'b0;
    i_hs = 1'b1;
    i_vs = 1'b1;
    i_mode = 3'd0;
    i_hres = 16'd64;
    i_solid_rgb = 24'h0;
    test_reset();
    test_bars();
    test_grid();
    test_checker();
    test_mode_change();
    test_bar_edge();
    test_solid();
    test_scroll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
